vector_player_checker: RTL and testbench
========================================

Name: vector_player_checker

Overview:
- Sequential stimulus/response engine for the other end of the combinational `dut` interface, which takes a 20-bit input vector and returns a 10-bit result.
- Stores up to DEPTH stimulus vectors, each with an expected result and a care mask, loaded through a write port.
- On start, drives each vector onto the DUT input, waits SETTLE cycles, samples the DUT output, compares it under the mask, and emits a result-write stream.
- Sits between the vector-file loader and the DUT, replacing the one-shot load/display/write-results flow with a clocked, self-checking player.

Parameters:
- IN_W, 20, DUT input width (stimulus vector width).
- OUT_W, 10, DUT output width (result, expected and mask width).
- DEPTH, 16, number of vector slots; must be a power of two.
- ADDR_W, 4, log2(DEPTH).
- SETTLE, 1, wait cycles between driving a vector and sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load_en  input  1  write one vector slot this cycle; ignored while busy.
- load_addr  input  ADDR_W  slot index.
- load_stim  input  IN_W  stimulus vector.
- load_exp  input  OUT_W  expected DUT output.
- load_mask  input  OUT_W  care bits; 1 = compare this bit.
- num_vec  input  ADDR_W+1  vectors to run (0..DEPTH); sampled on accepted start.
- start  input  1  one-cycle run request; ignored unless IDLE.
- dut_in  output  IN_W  registered drive to the DUT input.
- dut_out  input  OUT_W  DUT output, combinational from dut_in.
- res_we  output  1  one-cycle result-write strobe.
- res_addr  output  ADDR_W  index of the vector being reported.
- res_data  output  OUT_W  sampled dut_out.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  1 when the last run had zero mismatches; held until the next accepted start.
- err_count  output  ADDR_W+1  number of mismatching vectors in the current or last run.
- first_err_idx  output  ADDR_W  index of the first mismatching vector.
- first_err_got  output  OUT_W  dut_out value captured at the first mismatch.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - dut_in, res_we, res_addr, res_data, busy, done, err_count, first_err_idx and first_err_got are all 0.
  - pass is 0.
  - Vector memory is not reset; its contents survive reset.
- States: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- IDLE:
  - load_en writes stim/exp/mask to slot load_addr at the clock edge.
  - When start=1: latch num_vec; clear err_count, first_err_idx, first_err_got and pass; set idx=0.
  - If the latched num_vec is 0, go to DONE; otherwise go to DRIVE.
- DRIVE (1 cycle): dut_in <= stim[idx]; settle counter <= SETTLE; go to WAIT.
- WAIT: decrement the counter each cycle; after exactly SETTLE cycles, go to SAMPLE.
- SAMPLE (1 cycle):
  - Register res_we=1, res_addr=idx, res_data=dut_out, so all three are visible in the following cycle.
  - Mismatch is defined as ((dut_out ^ exp[idx]) & mask[idx]) != 0.
  - On a mismatch, err_count increments. If this is the first mismatch of the run, also capture first_err_idx=idx and first_err_got=dut_out.
  - If idx == num_vec-1, go to DONE; otherwise idx++ and go to DRIVE.
- DONE (1 cycle): done=1; pass = (err_count==0), using the final count including the last sample; go to IDLE.
- dut_in holds the last driven vector after the run and until reset.
- Latency:
  - Each vector takes SETTLE+2 cycles (DRIVE + WAIT×SETTLE + SAMPLE).
  - done is high in cycle num_vec×(SETTLE+2)+1 after the start edge.
  - With num_vec=0, done is high in the cycle immediately after the start edge.
- busy is 1 from the cycle after start through DONE inclusive.
- Boundary conditions:
  - num_vec > DEPTH is clamped to DEPTH.
  - A full run with num_vec=DEPTH ends at idx=DEPTH-1 with no wrap.
  - load_en while busy is dropped; memory is unchanged.
  - start while busy is dropped.
  - If start and load_en arrive in the same IDLE cycle, the write completes and the run begins. Slot 0 is read in DRIVE one cycle later, so the newly written data is visible.
  - err_count cannot exceed DEPTH, so no saturation logic is needed.
  - Reset during a run aborts it immediately: no done pulse, and no res_we is issued after reset.
  - Masked-off bits are never compared; mask=0 always matches.

Test Plan:
1. Loopback DUT model (dut_out=dut_in[9:0]); load slot0 stim=20'h003A5, exp=10'h3A5, mask=10'h3FF; num_vec=1, SETTLE=1, start -> res_we pulse with res_addr=0, res_data=10'h3A5; done in cycle 4 after the start edge; pass=1; err_count=0.
2. Loopback, 3 vectors where slot1 exp=10'h001 but dut_out=10'h000, all masks 3FF -> three res_we pulses at addr 0,1,2; err_count=1; first_err_idx=1; first_err_got=10'h000; pass=0; done in cycle 10.
3. Same as scenario 2 but slot1 mask=10'h3FE -> err_count=0, pass=1.
4. num_vec=0 with start -> done in the next cycle; pass=1; no res_we.
5. num_vec=16 with all slots loaded and loopback -> 16 res_we pulses with addr 0..15 in order, no 17th pulse; then a second start with num_vec=20 is clamped to 16 and gives the same result.
6. Assert rst_n=0 during WAIT of vector 2 -> all outputs 0 within the same cycle, no done pulse; after release, start with num_vec=1 replays slot0 data, which was retained through reset.

Source files
------------

// File: rtl/vector_player_checker.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vector_player_checker: clocked stimulus player / masked response checker    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module vector_player_checker #(
  parameter int IN_W   = 20,
  parameter int OUT_W  = 10,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [IN_W-1:0]   load_stim,
  input  logic [OUT_W-1:0]  load_exp,
  input  logic [OUT_W-1:0]  load_mask,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              start,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [OUT_W-1:0]  res_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [OUT_W-1:0]  first_err_got
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] c_DEPTH  = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      c_SETTLE = 4'(SETTLE);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [IN_W-1:0]   r_stim [DEPTH];
  logic [OUT_W-1:0]  r_exp  [DEPTH];
  logic [OUT_W-1:0]  r_mask [DEPTH];

  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W:0]   r_num;
  logic [3:0]        r_cnt;
  logic [IN_W-1:0]   r_dut_in;
  logic              r_res_we;
  logic [ADDR_W-1:0] r_res_addr;
  logic [OUT_W-1:0]  r_res_data;
  logic              r_pass;
  logic [ADDR_W:0]   r_err_count;
  logic [ADDR_W-1:0] r_first_err_idx;
  logic [OUT_W-1:0]  r_first_err_got;

  logic              w_idle;
  logic              w_last;
  logic              w_mis;
  logic [ADDR_W:0]   w_err_nxt;

  assign w_idle    = (r_state == S_IDLE);
  assign w_last    = ({1'b0, r_idx} == (r_num - 1'b1));
  assign w_mis     = |((dut_out ^ r_exp[r_idx]) & r_mask[r_idx]);
  assign w_err_nxt = r_err_count + {{ADDR_W{1'b0}}, w_mis};

  // Vector memory has no reset so loaded vectors survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_idle && load_en) begin
      r_stim[load_addr] <= load_stim;
      r_exp[load_addr]  <= load_exp;
      r_mask[load_addr] <= load_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = (num_vec == '0) ? S_DONE : S_DRIVE;
      S_DRIVE:  w_state_nxt = S_WAIT;
      S_WAIT:   if (r_cnt == 4'd1) w_state_nxt = S_SAMPLE;
      S_SAMPLE: w_state_nxt = w_last ? S_DONE : S_DRIVE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // pass is resolved on entry to DONE so it is valid alongside the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx           <= '0;
      r_num           <= '0;
      r_cnt           <= '0;
      r_dut_in        <= '0;
      r_res_we        <= 1'b0;
      r_res_addr      <= '0;
      r_res_data      <= '0;
      r_pass          <= 1'b0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
      r_first_err_got <= '0;
    end else begin
      r_res_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num           <= (num_vec > c_DEPTH) ? c_DEPTH : num_vec;
            r_idx           <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_first_err_got <= '0;
            r_pass          <= (num_vec == '0);
          end
        end
        S_DRIVE: begin
          r_dut_in <= r_stim[r_idx];
          r_cnt    <= c_SETTLE;
        end
        S_WAIT: r_cnt <= r_cnt - 4'd1;
        S_SAMPLE: begin
          r_res_we   <= 1'b1;
          r_res_addr <= r_idx;
          r_res_data <= dut_out;
          if (w_mis) begin
            r_err_count <= w_err_nxt;
            if (r_err_count == '0) begin
              r_first_err_idx <= r_idx;
              r_first_err_got <= dut_out;
            end
          end
          if (w_last) r_pass <= (w_err_nxt == '0);
          else        r_idx  <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dut_in        = r_dut_in;
  assign res_we        = r_res_we;
  assign res_addr      = r_res_addr;
  assign res_data      = r_res_data;
  assign busy          = !w_idle;
  assign done          = (r_state == S_DONE);
  assign pass          = r_pass;
  assign err_count     = r_err_count;
  assign first_err_idx = r_first_err_idx;
  assign first_err_got = r_first_err_got;

endmodule
`default_nettype wire

// File: tb/tb_vector_player_checker.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_vector_player_checker: randomized scoreboard bench for the vector player |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_vector_player_checker;
  localparam int IN_W   = 20;
  localparam int OUT_W  = 10;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int SETTLE = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_en = 1'b0;
  logic [AW-1:0]     load_addr = '0;
  logic [IN_W-1:0]   load_stim = '0;
  logic [OUT_W-1:0]  load_exp = '0;
  logic [OUT_W-1:0]  load_mask = '0;
  logic [AW:0]       num_vec = '0;
  logic              start = 1'b0;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              res_we;
  logic [AW-1:0]     res_addr;
  logic [OUT_W-1:0]  res_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic [AW:0]       err_count;
  logic [AW-1:0]     first_err_idx;
  logic [OUT_W-1:0]  first_err_got;

  vector_player_checker #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(AW), .SETTLE(SETTLE)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_addr(load_addr), .load_stim(load_stim),
    .load_exp(load_exp), .load_mask(load_mask),
    .num_vec(num_vec), .start(start),
    .dut_in(dut_in), .dut_out(dut_out),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_got(first_err_got)
  );

  always #5 clk = ~clk;

  // Device under check: loopback with the upper stimulus bits folded in.
  assign dut_out = dut_in[9:0] ^ dut_in[19:10];

  function automatic logic [OUT_W-1:0] fdut(input logic [IN_W-1:0] s);
    return s[9:0] ^ s[19:10];
  endfunction

  typedef struct {
    logic [AW-1:0]    addr;
    logic [OUT_W-1:0] data;
  } res_t;

  typedef struct {
    int               cyc;
    logic             pass;
    logic [AW:0]      errs;
    logic [AW-1:0]    fidx;
    logic [OUT_W-1:0] fgot;
  } sum_t;

  res_t res_q[$];
  sum_t sum_q[$];
  res_t mr;
  sum_t ms;

  logic [IN_W-1:0]  m_stim [DEPTH];
  logic [OUT_W-1:0] m_exp  [DEPTH];
  logic [OUT_W-1:0] m_mask [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result or done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_we) begin
        if (res_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL res_we_unexpected: got addr %0d data %h, want no write", res_addr, res_data);
        end else begin
          mr = res_q.pop_front();
          chk("res_addr", 32'(res_addr), 32'(mr.addr));
          chk("res_data", 32'(res_data), 32'(mr.data));
        end
      end
      if (done) begin
        if (sum_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: got done=1, want 0 (t=%0t)", $time);
        end else begin
          ms = sum_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(ms.cyc));
          chk("pass", 32'(pass), 32'(ms.pass));
          chk("err_count", 32'(err_count), 32'(ms.errs));
          chk("first_err_idx", 32'(first_err_idx), 32'(ms.fidx));
          chk("first_err_got", 32'(first_err_got), 32'(ms.fgot));
          chk("res_all_before_done", 32'(res_q.size()), 32'd0);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_dut_in"}, 32'(dut_in), 32'd0);
    chk({tag, "_res_we"}, 32'(res_we), 32'd0);
    chk({tag, "_res_addr"}, 32'(res_addr), 32'd0);
    chk({tag, "_res_data"}, 32'(res_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_first_err_idx"}, 32'(first_err_idx), 32'd0);
    chk({tag, "_first_err_got"}, 32'(first_err_got), 32'd0);
  endtask

  // Called and returns at a falling edge.
  task automatic load(input logic [AW-1:0] a, input logic [IN_W-1:0] s,
                      input logic [OUT_W-1:0] e, input logic [OUT_W-1:0] m);
    load_en = 1'b1; load_addr = a; load_stim = s; load_exp = e; load_mask = m;
    m_stim[a] = s; m_exp[a] = e; m_mask[a] = m;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic run(input int n, input bit poke = 1'b0, input int abort_at = 0,
                     input bit wl = 1'b0, input logic [AW-1:0] wa = '0,
                     input logic [IN_W-1:0] ws = '0, input logic [OUT_W-1:0] we = '0,
                     input logic [OUT_W-1:0] wm = '0);
    int nn;
    int errs;
    logic [AW-1:0]    fidx;
    logic [OUT_W-1:0] fgot;
    logic [OUT_W-1:0] got;
    res_t r;
    sum_t s;
    if (wl) begin
      load_en = 1'b1; load_addr = wa; load_stim = ws; load_exp = we; load_mask = wm;
      m_stim[wa] = ws; m_exp[wa] = we; m_mask[wa] = wm;
    end
    nn = (n > DEPTH) ? DEPTH : n;
    errs = 0; fidx = '0; fgot = '0;
    for (int i = 0; i < nn; i++) begin
      got = fdut(m_stim[i]);
      r.addr = AW'(i); r.data = got;
      res_q.push_back(r);
      if (((got ^ m_exp[i]) & m_mask[i]) != '0) begin
        if (errs == 0) begin fidx = AW'(i); fgot = got; end
        errs++;
      end
    end
    s.cyc = cyc + 1 + nn * (SETTLE + 2);
    s.pass = (errs == 0);
    s.errs = (AW+1)'(errs);
    s.fidx = fidx;
    s.fgot = fgot;
    sum_q.push_back(s);
    num_vec = (AW+1)'(n);
    start = 1'b1;
    @(posedge clk);
    #1 chk("busy_after_start", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    if (poke) begin
      load_en = 1'b1; load_addr = '0; load_stim = m_stim[0] ^ 20'hFFFFF;
      load_exp = ~m_exp[0]; load_mask = 10'h3FF; start = 1'b1; num_vec = 5'd1;
      @(negedge clk);
      load_en = 1'b0; start = 1'b0;
    end
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(negedge clk);
      #2 rst_n = 1'b0;
      res_q.delete();
      sum_q.delete();
      #1 chk_zero("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_idle_busy", 32'(busy), 32'd0);
    end else begin
      for (int k = 0; k < 400 && sum_q.size() != 0; k++) @(negedge clk);
      if (sum_q.size() != 0) begin
        n_cmp++; n_bad++;
        $display("FAIL run_timeout: got no done after 400 cycles, want done");
        sum_q.delete();
      end
      res_q.delete();
      @(negedge clk);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("pass_held", 32'(pass), 32'(s.pass));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0]  st;
    logic [OUT_W-1:0] ex;
    #1 chk_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    load(4'd0, 20'h003A5, 10'h3A5, 10'h3FF);
    run(1);

    load(4'd1, 20'h00000, 10'h001, 10'h3FF);
    load(4'd2, 20'h00155, 10'h155, 10'h3FF);
    run(3);

    load(4'd1, 20'h00000, 10'h001, 10'h3FE);
    run(3);

    run(0);

    for (int i = 0; i < DEPTH; i++) begin
      st = {10'h000, 10'($urandom)};
      load(AW'(i), st, st[9:0], 10'h3FF);
    end
    run(16);
    run(20);

    for (int i = 0; i < DEPTH; i++) begin
      st = 20'($urandom);
      ex = fdut(st);
      if ($urandom_range(0, 2) == 0) ex = ex ^ 10'($urandom);
      load(AW'(i), st, ex, ($urandom_range(0, 3) == 0) ? 10'h000 : 10'($urandom));
    end
    for (int t = 0; t < 6; t++) run(int'($urandom_range(0, 20)));
    run(5, 1'b1);
    run(4, 1'b0, 0, 1'b1, 4'd0, 20'($urandom), 10'($urandom), 10'h3FF);
    run(16);

    run(3, 1'b0, 5);
    run(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
